mem_lsu: RTL

//  MEM-stage load/store unit fed directly by the EX/MEM pipeline register. Non-memory ops pass

---
 rtl/mem_lsu.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: single-beat request/ack bus master with big-endian lane handling,
// LL/SC link bit and an ack watchdog. Non-memory ops flow straight through to MEM/WB.
module mem_lsu #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic        llbit_clr,
  input  logic        bus_ack,
  input  logic [31:0] bus_dat_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_dat_o
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_LL  = 8'b1111_0000;
  localparam logic [7:0] OP_SC  = 8'b1111_1000;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_reg, state_next;
  logic                   cyc_reg, we_reg, timed_out_reg, bus_err_reg, llbit_reg;
  logic [3:0]             sel_reg;
  logic [31:0]            addr_reg, dat_reg, rdata_reg;
  logic [TIMEOUT_W-1:0]   cnt_reg;

  logic        is_byte, is_half, is_word, is_store, is_mem;
  logic        misaligned, sc_fail, start, abort, cnt_max;
  logic [3:0]  sel_next;
  logic [31:0] dat_next, load_data;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Only the MEM-stage hold bit matters here.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    is_store = 1'b0;
    case (aluop_i)
      OP_LB, OP_LBU: is_byte = 1'b1;
      OP_LH, OP_LHU: is_half = 1'b1;
      OP_LW, OP_LL:  is_word = 1'b1;
      OP_SB:         begin is_byte = 1'b1; is_store = 1'b1; end
      OP_SH:         begin is_half = 1'b1; is_store = 1'b1; end
      OP_SW, OP_SC:  begin is_word = 1'b1; is_store = 1'b1; end
      default:       ;
    endcase
  end

  assign is_mem     = is_byte | is_half | is_word;
  assign misaligned = (is_half & mem_addr_i[0]) | (is_word & (|mem_addr_i[1:0]));
  assign sc_fail    = (aluop_i == OP_SC) & ~llbit_reg;
  assign start      = (state_reg == IDLE) & is_mem & ~misaligned & ~sc_fail;
  assign cnt_max    = &cnt_reg;
  assign abort      = (state_reg == BUSY) & ~bus_ack & cnt_max;

  always_comb begin
    sel_next = 4'b1111;
    dat_next = reg2_i;
    if (is_byte) begin
      sel_next = 4'b1000 >> mem_addr_i[1:0];
      dat_next = {4{reg2_i[7:0]}};
    end else if (is_half) begin
      sel_next = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      dat_next = {2{reg2_i[15:0]}};
    end
  end

  // Big-endian: lane 0 of the word lives in the top byte.
  assign byte_val = rdata_reg[{~mem_addr_i[1:0], 3'b000} +: 8];
  assign half_val = rdata_reg[{~mem_addr_i[1], 4'b0000} +: 16];

  always_comb begin
    case (aluop_i)
      OP_LB:   load_data = {{24{byte_val[7]}}, byte_val};
      OP_LBU:  load_data = {24'h0, byte_val};
      OP_LH:   load_data = {{16{half_val[15]}}, half_val};
      OP_LHU:  load_data = {16'h0, half_val};
      default: load_data = rdata_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (bus_ack || cnt_max) state_next = DONE;
      DONE:    if (!stall[4]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wd_o     = wd_i;
    wreg_o   = wreg_i;
    wdata_o  = wdata_i;
    hi_o     = hi_i;
    lo_o     = lo_i;
    whilo_o  = whilo_i;
    stallreq = 1'b0;
    addr_err = 1'b0;
    if (rst) begin
      wd_o    = 5'h0;
      wreg_o  = 1'b0;
      wdata_o = 32'h0;
      hi_o    = 32'h0;
      lo_o    = 32'h0;
      whilo_o = 1'b0;
    end else if (is_mem) begin
      if (misaligned) begin
        addr_err = 1'b1;
        wreg_o   = 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (sc_fail) begin
              wreg_o  = 1'b1;
              wdata_o = 32'h0;
            end else begin
              stallreq = 1'b1;
              wreg_o   = 1'b0;
            end
          end
          BUSY: begin
            stallreq = 1'b1;
            wreg_o   = 1'b0;
          end
          DONE: begin
            if (aluop_i == OP_SC) begin
              wreg_o  = ~timed_out_reg;
              wdata_o = 32'h1;
            end else begin
              wreg_o = wreg_i & ~timed_out_reg;
              if (!is_store) wdata_o = load_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= 4'h0;
      addr_reg      <= 32'h0;
      dat_reg       <= 32'h0;
      rdata_reg     <= 32'h0;
      cnt_reg       <= '0;
      timed_out_reg <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      bus_err_reg <= abort;
      if (start) begin
        cyc_reg       <= 1'b1;
        we_reg        <= is_store;
        sel_reg       <= sel_next;
        addr_reg      <= {mem_addr_i[31:2], 2'b00};
        dat_reg       <= dat_next;
        cnt_reg       <= '0;
        timed_out_reg <= 1'b0;
      end else if (state_reg == BUSY) begin
        if (bus_ack) begin
          cyc_reg   <= 1'b0;
          rdata_reg <= bus_dat_i;
        end else if (cnt_max) begin
          cyc_reg       <= 1'b0;
          timed_out_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + TIMEOUT_W'(1);
        end
      end
    end
  end

  // A clear request beats a link set on the same edge.
  always_ff @(posedge clk) begin
    if (rst || llbit_clr) begin
      llbit_reg <= 1'b0;
    end else if (state_reg == BUSY && bus_ack) begin
      if (aluop_i == OP_LL)      llbit_reg <= 1'b1;
      else if (aluop_i == OP_SC) llbit_reg <= 1'b0;
    end
  end

  assign bus_cyc   = cyc_reg;
  assign bus_stb   = cyc_reg;
  assign bus_we    = we_reg;
  assign bus_sel   = sel_reg;
  assign bus_addr  = addr_reg;
  assign bus_dat_o = dat_reg;
  assign bus_err   = bus_err_reg;

endmodule
